pulse_width_decoder: RTL and testbench

Receive-side counterpart of the pulse stretcher. Takes a stretched pulse and measures its width in clk cycles. If the width is within tolerance, it collapses the pulse back to a single-cycle strobe; otherwise it flags a short or long width error. Sits at the destination of any stretched event line, e.g. a slow-domain or off-chip event that must be recovered as a one-cycle strobe.

---
 rtl/pulse_pkg.sv | 16 +
 rtl/pulse_width_decoder_if.sv | 35 +++
 rtl/pulse_sync_2ff.sv | 31 +++
 rtl/pulse_width_decoder.sv | 121 ++++++++++++
 tb/tb_pulse_width_decoder.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared state encodings and default pulse stretch constants
package pulse_pkg;

  // FSM encodings for the pulse width decoder
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEASURE  = 2'd1,
    OVERLONG = 2'd2
  } state_e;

  // Defaults shared with the pulse stretcher so both ends agree on the width
  localparam int DEF_STRETCH_LEN = 4;
  localparam int DEF_TOL         = 1;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/pulse_width_decoder_if.sv
// rtl/pulse_width_decoder_if.sv - pulse input and decoded strobe/width bundle
interface pulse_width_decoder_if
  import pulse_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             pulse_in;
  logic             pulse_out;
  logic [CNT_W-1:0] width_out;
  logic             width_valid;
  logic             err_short;
  logic             err_long;

  // Source of the stretched pulse, consumer of the decoded results
  modport master (
    output pulse_in,
    input  pulse_out,
    input  width_out,
    input  width_valid,
    input  err_short,
    input  err_long
  );

  // The decoder itself
  modport slave (
    input  pulse_in,
    output pulse_out,
    output width_out,
    output width_valid,
    output err_short,
    output err_long
  );

endinterface

// File: rtl/pulse_sync_2ff.sv
// rtl/pulse_sync_2ff.sv - two-flop synchronizer for an asynchronous level, reset to 0
module pulse_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values simply shift the input down the chain
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pulse_width_decoder.sv
// rtl/pulse_width_decoder.sv - measures stretched pulse width, emits strobe or error (PULSE_WIDTH_DECODER_SYNC_EN adds input synchronizer)
module pulse_width_decoder
  import pulse_pkg::*;
#(
  parameter int STRETCH_LEN = DEF_STRETCH_LEN,
  parameter int TOL         = DEF_TOL,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic                  clk,
  input logic                  rst,
  pulse_width_decoder_if.slave bus
);

  // Window bounds in counter width; cnt saturates at the upper bound
  localparam logic [CNT_W-1:0] MIN_W = CNT_W'(STRETCH_LEN - TOL);
  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(STRETCH_LEN + TOL);

  logic pulse_s;

`ifdef PULSE_WIDTH_DECODER_SYNC_EN
  pulse_sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pulse_in),
    .q   (pulse_s)
  );
`else
  assign pulse_s = bus.pulse_in;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             pulse_out_q, pulse_out_d;
  logic             width_valid_q, width_valid_d;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    width_d       = width_q;
    pulse_out_d   = 1'b0;
    width_valid_d = 1'b0;
    err_short_d   = 1'b0;
    err_long_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pulse_s) begin
          state_d = MEASURE;
          cnt_d   = CNT_W'(1);
        end
      end

      MEASURE: begin
        if (pulse_s) begin
          if (cnt_q < MAX_W) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            // Too long already: flag once and stop counting, width_out keeps old value
            err_long_d = 1'b1;
            state_d    = OVERLONG;
          end
        end else begin
          // Falling edge seen; cnt never exceeds MAX_W here, so only the low bound matters
          state_d       = IDLE;
          cnt_d         = '0;
          width_d       = cnt_q;
          width_valid_d = 1'b1;
          if (cnt_q >= MIN_W) begin
            pulse_out_d = 1'b1;
          end else begin
            err_short_d = 1'b1;
          end
        end
      end

      OVERLONG: begin
        if (!pulse_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and output registers; reset abandons any measurement in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      width_q       <= '0;
      pulse_out_q   <= 1'b0;
      width_valid_q <= 1'b0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      width_q       <= width_d;
      pulse_out_q   <= pulse_out_d;
      width_valid_q <= width_valid_d;
      err_short_q   <= err_short_d;
      err_long_q    <= err_long_d;
    end
  end

  assign bus.pulse_out   = pulse_out_q;
  assign bus.width_out   = width_q;
  assign bus.width_valid = width_valid_q;
  assign bus.err_short   = err_short_q;
  assign bus.err_long    = err_long_q;

endmodule

// File: tb/tb_pulse_width_decoder.sv
// tb/tb_pulse_width_decoder.sv - directed table-driven bench for pulse_width_decoder
module tb_pulse_width_decoder;

`ifdef PULSE_WIDTH_DECODER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic rst;

  pulse_width_decoder_if #(.CNT_W(8)) bus ();

  pulse_width_decoder #(
    .STRETCH_LEN (4),
    .TOL         (1),
    .CNT_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    int hi;
    int exp_po;
    int exp_es;
    int exp_el;
    int exp_wv;
    int exp_width;
    int exp_idx;
  } vec_t;

  vec_t vecs [8];

  int n_vec;
  int n_err;

  int n_po, n_es, n_el, n_wv, n_excl;
  int first_idx, second_po_idx, wv_sum;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive pat[k] for len cycles from negedges, observing outputs before each drive
  task automatic run(input logic [31:0] pat, input int len);
    n_po = 0; n_es = 0; n_el = 0; n_wv = 0; n_excl = 0;
    first_idx = -1; second_po_idx = -1; wv_sum = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (bus.pulse_out) begin
        if (n_po == 1) second_po_idx = k;
        n_po++;
      end
      if (bus.err_short) n_es++;
      if (bus.err_long) n_el++;
      if (bus.width_valid) begin
        n_wv++;
        wv_sum += int'(bus.width_out);
      end
      if (first_idx < 0 && (bus.pulse_out || bus.err_short || bus.err_long)) first_idx = k;
      if ((int'(bus.pulse_out) + int'(bus.err_short) + int'(bus.err_long)) > 1) n_excl++;
      bus.pulse_in = pat[k];
    end
  endtask

  initial begin
    logic [31:0] pat;
    n_vec = 0;
    n_err = 0;

    // hi, po, es, el, wv, width_out afterwards, index of first strobe (before LAT)
    vecs[0] = '{4, 1, 0, 0, 1, 4, 5};
    vecs[1] = '{3, 1, 0, 0, 1, 3, 4};
    vecs[2] = '{5, 1, 0, 0, 1, 5, 6};
    vecs[3] = '{2, 0, 1, 0, 1, 2, 3};
    vecs[4] = '{9, 0, 0, 1, 0, 2, 6};
    vecs[5] = '{4, 1, 0, 0, 1, 4, 5};
    vecs[6] = '{1, 0, 1, 0, 1, 1, 2};
    vecs[7] = '{6, 0, 0, 1, 0, 1, 6};

    rst = 1'b1;
    bus.pulse_in = 1'b0;
    #35;
    rst = 1'b0;
    #1;
    chk("reset pulse_out", int'(bus.pulse_out), 0);
    chk("reset width_out", int'(bus.width_out), 0);
    chk("reset width_valid", int'(bus.width_valid), 0);
    chk("reset err_short", int'(bus.err_short), 0);
    chk("reset err_long", int'(bus.err_long), 0);

    for (int i = 0; i < 8; i++) begin
      pat = (32'd1 << vecs[i].hi) - 32'd1;
      run(pat, vecs[i].hi + 6 + LAT);
      chk($sformatf("v%0d pulse_out count", i), n_po, vecs[i].exp_po);
      chk($sformatf("v%0d err_short count", i), n_es, vecs[i].exp_es);
      chk($sformatf("v%0d err_long count", i), n_el, vecs[i].exp_el);
      chk($sformatf("v%0d width_valid count", i), n_wv, vecs[i].exp_wv);
      chk($sformatf("v%0d width_out", i), int'(bus.width_out), vecs[i].exp_width);
      chk($sformatf("v%0d strobe index", i), first_idx, vecs[i].exp_idx + LAT);
      chk($sformatf("v%0d exclusive strobes", i), n_excl, 0);
    end

    // Two 4-cycle pulses separated by a single low cycle
    run(32'h0000_01EF, 16 + LAT);
    chk("b2b pulse_out count", n_po, 2);
    chk("b2b first index", first_idx, 5 + LAT);
    chk("b2b second index", second_po_idx, 10 + LAT);
    chk("b2b width sum", wv_sum, 8);
    chk("b2b width_out", int'(bus.width_out), 4);
    chk("b2b errors", n_es + n_el, 0);

    // Asynchronous reset in the middle of a 4-cycle pulse
    @(negedge clk);
    bus.pulse_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst pulse_out", int'(bus.pulse_out), 0);
    chk("midrst width_out", int'(bus.width_out), 0);
    chk("midrst width_valid", int'(bus.width_valid), 0);
    chk("midrst err_short", int'(bus.err_short), 0);
    chk("midrst err_long", int'(bus.err_long), 0);
    bus.pulse_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(32'h0, 8 + LAT);
    chk("postrst strobes", n_po + n_es + n_el + n_wv, 0);
    chk("postrst width_out", int'(bus.width_out), 0);
    run(32'h0000_000F, 10 + LAT);
    chk("postrst pulse_out count", n_po, 1);
    chk("postrst index", first_idx, 5 + LAT);
    chk("postrst width_out", int'(bus.width_out), 4);
    chk("postrst errors", n_es + n_el, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
